// File: rtl/au_pkg.sv
// Shared definitions for the sequential Arithmetic Unit blocks.
// The state encoding is common to every sequential AU block, so keep these values fixed.
package au_pkg;

    typedef logic [1:0] au_state_t;

    localparam au_state_t ST_IDLE = 2'd0;
    localparam au_state_t ST_CALC = 2'd1;
    localparam au_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/ripple_adder_n.sv
// Ripple-carry adder built from a chain of full_adder cells.
// For subtraction, the caller inverts b and drives cin high.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module ripple_adder_n #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[N];

endmodule

// File: rtl/seq_multiplier_n.sv
// Shift-and-add WIDTH x WIDTH multiplier: one adder, WIDTH iterations, valid/ready on both sides.
// Define MULT_SIGNED_EN for two's-complement operands; the default build is unsigned.
module seq_multiplier_n
    import au_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P,
    output logic               busy
);

    au_state_t          state;
    au_state_t          state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;

    logic               accept;
    logic               last_iter;
    logic [WIDTH-1:0]   prod_hi;
    logic [WIDTH:0]     add_a;
    logic [WIDTH:0]     add_b;
    logic               add_cin;
    logic [WIDTH:0]     sum;
    logic               unused_cout;

    assign accept    = in_valid & in_ready;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign prod_hi   = prod[2*WIDTH-1:WIDTH];

`ifdef MULT_SIGNED_EN
    logic             sub_iter;
    logic [WIDTH:0]   mcand_ext;

    // The final iteration weighs the multiplier's sign bit negatively, so it subtracts.
    assign sub_iter  = last_iter & prod[0];
    assign mcand_ext = {mcand[WIDTH-1], mcand};
    assign add_a     = {prod_hi[WIDTH-1], prod_hi};
    assign add_b     = prod[0] ? (sub_iter ? ~mcand_ext : mcand_ext) : '0;
    assign add_cin   = sub_iter;
`else
    assign add_a     = {1'b0, prod_hi};
    assign add_b     = prod[0] ? {1'b0, mcand} : '0;
    assign add_cin   = 1'b0;
`endif

    ripple_adder_n #(
        .N (WIDTH + 1)
    ) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (sum),
        .cout (unused_cout)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                if (last_iter) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = in_valid ? ST_CALC : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs; the product is only exposed while it is valid
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        P         = '0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_CALC: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                P         = prod;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Operand and partial-product registers; the upper half takes the full WIDTH+1-bit sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand <= '0;
            prod  <= '0;
            cnt   <= '0;
        end else if (accept) begin
            mcand <= A;
            prod  <= {{WIDTH{1'b0}}, B};
            cnt   <= '0;
        end else if (state == ST_CALC) begin
            prod  <= {sum, prod[WIDTH-1:1]};
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Scoreboard bench for seq_multiplier_n at WIDTH=4; honours MULT_SIGNED_EN when defined.
module tb_seq_multiplier_n;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] P;
    logic           busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit rnd_on;
    logic [2*W-1:0] exp_q[$];

    seq_multiplier_n #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference product from plain integer arithmetic on the operand interpretation
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int ia, ib;
`ifdef MULT_SIGNED_EN
        ia = int'($signed(a));
        ib = int'($signed(b));
`else
        ia = int'(a);
        ib = int'(b);
`endif
        return (2*W)'(ia * ib);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Stimulus side of the scoreboard: every accepted operand pair queues its product
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) exp_q.push_back(model(A, B));
    end

    // Monitor: every retired product is compared with the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_unexpected_output", 32'(P), 32'hFFFF_FFFF);
            else check("sb_product", 32'(P), 32'(exp_q.pop_front()));
        end
    end

    // Called just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        A = a;
        B = b;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Waits on falling edges until out_valid; lat counts those edges, bsy the busy ones
    task automatic wait_out(output logic [2*W-1:0] p, output int lat, output int bsy);
        lat = 0;
        bsy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) bsy++;
        end while (!out_valid && lat < 50);
        if (!out_valid) check("output_timeout", 32'd0, 32'd1);
        p = P;
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W-1:0] req, input string name);
        logic [2*W-1:0] p;
        int lat, bsy;
        out_ready = 1'b1;
        send(a, b);
        wait_out(p, lat, bsy);
        check(name, 32'(p), 32'(req));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [2*W-1:0] p, held;
        int lat, bsy, prev, t;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;

        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_P", 32'(P), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 15 x 15 with latency and busy-duration checks
        out_ready = 1'b1;
        send(4'd15, 4'd15);
        wait_out(p, lat, bsy);
        check("max_product", 32'(p), 32'hE1);
        check("latency_cycles", 32'(lat), 32'd5);
        check("busy_cycles", 32'(bsy), 32'd4);
        @(posedge clk);
        #1;

        op(4'd0, 4'd9, 8'd0, "zero_times_nine");
        op(4'd9, 4'd1, 8'd9, "nine_times_one");

        // Exhaustive sweep, checked by the scoreboard
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                out_ready = 1'b1;
                send(W'(a), W'(b));
                wait_out(p, lat, bsy);
                @(posedge clk);
                #1;
            end
        end

        // Backpressure: result must stay put and new operands must be refused
        out_ready = 1'b0;
        send(4'd9, 4'd7);
        wait_out(held, lat, bsy);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom_range(1));
            A = W'($urandom);
            B = W'($urandom);
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_P_stable", 32'(P), 32'(held));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        check("bp_busy_low", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Back-to-back: accepts exactly every 5 cycles with a retire on each
        out_ready = 1'b1;
        in_valid = 1'b1;
        A = W'($urandom);
        B = W'($urandom);
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            int n;
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            t = cyc;
            if (k > 0) begin
                check("b2b_period", 32'(t - prev), 32'd5);
                check("b2b_retire_with_accept", 32'(out_valid), 32'd1);
            end
            prev = t;
            @(posedge clk);
            #1;
            A = W'($urandom);
            B = W'($urandom);
        end
        in_valid = 1'b0;
        drain();

        // Randomised traffic with random consumer stalls
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(3) != 0);
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    send(W'($urandom), W'($urandom));
                    repeat ($urandom_range(2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_on = 1'b0;
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset during the third calculation cycle aborts the operation
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(4'd15, 4'd15);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_P", 32'(P), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        op(4'd3, 4'd5, 8'd15, "after_reset_3x5");

`ifdef MULT_SIGNED_EN
        op(4'h8, 4'h7, 8'hC8, "signed_m8_times_7");
        op(4'h8, 4'h8, 8'h40, "signed_m8_times_m8");
`else
        op(4'h8, 4'h7, 8'h38, "unsigned_8_times_7");
`endif

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
